// File: rtl/branch_target_predictor_pkg.sv
// Shared constants for the branch target predictor: branch type encodings,
// 2-bit direction counter states and the default table size.
package branch_target_predictor_pkg;

   localparam int ENTRIES_DEF = 64;

   localparam logic [2:0] NOBRANCH = 3'd0;
   localparam logic [2:0] BEQ      = 3'd1;
   localparam logic [2:0] BNE      = 3'd2;
   localparam logic [2:0] BLT      = 3'd3;
   localparam logic [2:0] BLTU     = 3'd4;
   localparam logic [2:0] BGE      = 3'd5;
   localparam logic [2:0] BGEU     = 3'd6;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
   import branch_target_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i && ctr_i != CTR_ST)       ctr_o = ctr_i + 2'd1;
      else if (!taken_i && ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: IF lookup, EX-stage
// training, misprediction redirect and branch/mispredict statistics.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PCF,
   output logic        PredTakenF,
   output logic [31:0] PredTargetF,
   input  logic [31:0] PCE,
   input  logic [2:0]  BranchTypeE,
   input  logic        BranchE,
   input  logic [31:0] BranchTargetE,
   input  logic        PredTakenE,
   input  logic [31:0] PredTargetE,
   input  logic        StallE,
   output logic        MispredictE,
   output logic [31:0] CorrectPCE,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredCount
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDX;

   logic [ENTRIES-1:0] valid_q;
   logic [TAGW-1:0]    tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];
   logic [31:0]        bcnt_q, bcnt_d;
   logic [31:0]        mcnt_q, mcnt_d;

   logic [IDX-1:0]  idx_f, idx_e;
   logic [TAGW-1:0] tag_f, tag_e;
   logic            hit_f, hit_e;
   logic            is_br, active, br_active;
   logic [1:0]      ctr_nxt;
   logic [31:0]     pce_plus4;
   logic            unused_pc_lsbs;

   assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

   assign idx_f = PCF[IDX+1:2];
   assign tag_f = PCF[31:IDX+2];
   assign idx_e = PCE[IDX+1:2];
   assign tag_e = PCE[31:IDX+2];

   // Lookup reads pre-update state; a same-cycle write is not bypassed.
   assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign PredTakenF  = hit_f && ctr_q[idx_f][1];
   assign PredTargetF = PredTakenF ? tgt_q[idx_f] : 32'd0;

   assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign is_br     = (BranchTypeE != NOBRANCH);
   assign active    = !StallE && (is_br || PredTakenE);
   assign br_active = active && is_br;
   assign pce_plus4 = PCE + 32'd4;

   // A predicted-taken non-branch is a stale entry: always redirect to PC+4.
   always_comb begin
      MispredictE = 1'b0;
      CorrectPCE  = pce_plus4;
      if (br_active) begin
         MispredictE = (PredTakenE != BranchE) ||
                       (PredTakenE && BranchE && (PredTargetE != BranchTargetE));
         if (BranchE) CorrectPCE = BranchTargetE;
      end else if (active) begin
         MispredictE = 1'b1;
      end
   end

   sat_counter2 u_ctr (
      .ctr_i  (ctr_q[idx_e]),
      .taken_i(BranchE),
      .ctr_o  (ctr_nxt)
   );

   assign bcnt_d = br_active   ? bcnt_q + 32'd1 : bcnt_q;
   assign mcnt_d = MispredictE ? mcnt_q + 32'd1 : mcnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= CTR_WNT;
         end
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         if (br_active) begin
            if (hit_e) begin
               ctr_q[idx_e] <= ctr_nxt;
               if (BranchE) tgt_q[idx_e] <= BranchTargetE;
            end else if (BranchE) begin
               valid_q[idx_e] <= 1'b1;
               tag_q[idx_e]   <= tag_e;
               tgt_q[idx_e]   <= BranchTargetE;
               ctr_q[idx_e]   <= CTR_WT;
            end
         end else if (active && hit_e) begin
            valid_q[idx_e] <= 1'b0;
         end
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   assign BranchCount  = bcnt_q;
   assign MispredCount = mcnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed table-driven bench for branch_target_predictor (ENTRIES=64).
module tb_branch_target_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] PCF = '0, PCE = '0, BranchTargetE = '0, PredTargetE = '0;
   logic [2:0]  BranchTypeE = '0;
   logic        BranchE = 1'b0, PredTakenE = 1'b0, StallE = 1'b0;
   logic        PredTakenF, MispredictE;
   logic [31:0] PredTargetF, CorrectPCE, BranchCount, MispredCount;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_target_predictor #(.ENTRIES(64)) dut (
      .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF),
      .PredTargetF(PredTargetF), .PCE(PCE), .BranchTypeE(BranchTypeE),
      .BranchE(BranchE), .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE),
      .PredTargetE(PredTargetE), .StallE(StallE), .MispredictE(MispredictE),
      .CorrectPCE(CorrectPCE), .BranchCount(BranchCount), .MispredCount(MispredCount)
   );

   typedef struct {
      logic [31:0] pcf, pce;
      logic [2:0]  bt;
      logic        br;
      logic [31:0] btgt;
      logic        ptk;
      logic [31:0] ptgt;
      logic        stall;
      logic        e_ptk;
      logic [31:0] e_ptgt;
      logic        e_mis;
      logic [31:0] e_cpc, e_bc, e_mc;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic [31:0] pcf, logic [31:0] pce, logic [2:0] bt,
                               logic br, logic [31:0] btgt, logic ptk, logic [31:0] ptgt,
                               logic stall, logic e_ptk, logic [31:0] e_ptgt, logic e_mis,
                               logic [31:0] e_cpc, logic [31:0] e_bc, logic [31:0] e_mc);
      vec_t v;
      v.pcf = pcf; v.pce = pce; v.bt = bt; v.br = br; v.btgt = btgt; v.ptk = ptk;
      v.ptgt = ptgt; v.stall = stall; v.e_ptk = e_ptk; v.e_ptgt = e_ptgt;
      v.e_mis = e_mis; v.e_cpc = e_cpc; v.e_bc = e_bc; v.e_mc = e_mc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      PCF = v.pcf; PCE = v.pce; BranchTypeE = v.bt; BranchE = v.br;
      BranchTargetE = v.btgt; PredTakenE = v.ptk; PredTargetE = v.ptgt; StallE = v.stall;
   endtask

   initial begin
      //        pcf    pce          bt  br btgt    ptk ptgt   st  e_ptk e_ptgt e_mis e_cpc  bc  mc
      tv.push_back(mk(32'h10, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   0, 32'h4,   0, 0));
      tv.push_back(mk(32'h10, 32'h40, 3'd1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0,   1, 32'h80,  0, 0));
      tv.push_back(mk(32'h40, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 1, 32'h80,  0, 32'h4,   1, 1));
      tv.push_back(mk(32'h40, 32'h40, 3'd1, 0, 32'h80, 1, 32'h80, 0, 1, 32'h80,  1, 32'h44,  1, 1));
      tv.push_back(mk(32'h40, 32'h40, 3'd1, 0, 32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 32'h44,  2, 2));
      tv.push_back(mk(32'h40, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   0, 32'h4,   3, 2));
      // retrain to strongly taken, then change target
      tv.push_back(mk(32'h40, 32'h40, 3'd1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0,   1, 32'h80,  3, 2));
      tv.push_back(mk(32'h40, 32'h40, 3'd1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0,   1, 32'h80,  4, 3));
      tv.push_back(mk(32'h40, 32'h40, 3'd1, 1, 32'h80, 1, 32'h80, 0, 1, 32'h80,  0, 32'h80,  5, 4));
      tv.push_back(mk(32'h40, 32'h40, 3'd1, 1, 32'h100,1, 32'h80, 0, 1, 32'h80,  1, 32'h100, 6, 4));
      tv.push_back(mk(32'h40, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 1, 32'h100, 0, 32'h4,   7, 5));
      // stale entry: non-branch predicted taken invalidates
      tv.push_back(mk(32'h40, 32'h40, 3'd0, 0, 32'h0,  1, 32'h100,0, 1, 32'h100, 1, 32'h44,  7, 5));
      tv.push_back(mk(32'h40, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   0, 32'h4,   7, 6));
      // aliasing: 0x40 and 0x140 share index 16
      tv.push_back(mk(32'h40, 32'h40, 3'd2, 1, 32'h200,0, 32'h0,  0, 0, 32'h0,   1, 32'h200, 7, 6));
      tv.push_back(mk(32'h40, 32'h140,3'd2, 1, 32'h300,0, 32'h0,  0, 1, 32'h200, 1, 32'h300, 8, 7));
      tv.push_back(mk(32'h40, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   0, 32'h4,   9, 8));
      tv.push_back(mk(32'h140,32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 1, 32'h300, 0, 32'h4,   9, 8));
      // stalled taken branch held three cycles
      tv.push_back(mk(32'h80, 32'h80, 3'd1, 1, 32'hC0, 0, 32'h0,  1, 0, 32'h0,   0, 32'h84,  9, 8));
      tv.push_back(mk(32'h80, 32'h80, 3'd1, 1, 32'hC0, 0, 32'h0,  1, 0, 32'h0,   0, 32'h84,  9, 8));
      tv.push_back(mk(32'h80, 32'h80, 3'd1, 1, 32'hC0, 0, 32'h0,  1, 0, 32'h0,   0, 32'h84,  9, 8));
      tv.push_back(mk(32'h80, 32'h80, 3'd1, 1, 32'hC0, 0, 32'h0,  0, 0, 32'h0,   1, 32'hC0,  9, 8));
      tv.push_back(mk(32'h80, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 1, 32'hC0,  0, 32'h4,  10, 9));
      // PC[1:0] ignored; PC+4 wraps
      tv.push_back(mk(32'h83, 32'hFFFFFFFC, 3'd5, 0, 32'h0, 0, 32'h0, 0, 1, 32'hC0, 0, 32'h0, 10, 9));
      tv.push_back(mk(32'h80, 32'h0, 3'd0, 0, 32'h0,   0, 32'h0,  0, 1, 32'hC0,  0, 32'h4,  11, 9));

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         chk($sformatf("v%0d PredTakenF", i),  {31'd0, PredTakenF},  {31'd0, tv[i].e_ptk});
         chk($sformatf("v%0d PredTargetF", i), PredTargetF,          tv[i].e_ptgt);
         chk($sformatf("v%0d MispredictE", i), {31'd0, MispredictE}, {31'd0, tv[i].e_mis});
         if (tv[i].e_mis || tv[i].bt != 3'd0)
            chk($sformatf("v%0d CorrectPCE", i), CorrectPCE, tv[i].e_cpc);
         chk($sformatf("v%0d BranchCount", i),  BranchCount,  tv[i].e_bc);
         chk($sformatf("v%0d MispredCount", i), MispredCount, tv[i].e_mc);
      end

      // asynchronous reset mid-cycle while a taken branch is pending
      @(negedge clk);
      drive(mk(32'h80, 32'h40, 3'd1, 1, 32'h80, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      chk("rst PredTakenF",   {31'd0, PredTakenF}, 32'd0);
      chk("rst PredTargetF",  PredTargetF, 32'd0);
      chk("rst BranchCount",  BranchCount, 32'd0);
      chk("rst MispredCount", MispredCount, 32'd0);
      // hold reset across an update edge; that update must be discarded
      @(negedge clk);
      drive(mk(32'h40, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
      rst_n = 1'b1;
      #1;
      chk("post-rst PredTakenF 0x40", {31'd0, PredTakenF}, 32'd0);
      chk("post-rst BranchCount",     BranchCount, 32'd0);
      chk("post-rst MispredCount",    MispredCount, 32'd0);
      @(negedge clk);
      PCF = 32'h140;
      #1;
      chk("post-rst PredTakenF 0x140", {31'd0, PredTakenF}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
